instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Front stage of the 4-bit-PC pipeline. Holds the fetch PC and a 16x16 instruction memory, loaded through a write port.
- Drives the IF/ID pipeline register: pc[3:0] and instruction[15:0] feed operand fetch directly.
- Supports stall, branch redirect with flush, and a HALT opcode that freezes fetch until resume or redirect.

Parameters:
- RESET_PC, 4'h0, fetch PC value loaded on reset.
- HALT_OPCODE, 4'hF, instruction[3:0] value that halts fetch.
- NOP_WORD, 16'h0000, word driven on instruction when the slot is invalid or flushed.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hold IF/ID register and fetch PC; from the hazard logic downstream.
- branch_taken  input  1  redirect request from execute.
- branch_target  input  4  new fetch PC when branch_taken=1.
- resume  input  1  leave HALTED and continue at halt address+1.
- imem_we  input  1  instruction memory write enable.
- imem_waddr  input  4  write address.
- imem_wdata  input  16  write data.
- pc  output  4  PC of the word in the IF/ID register.
- instruction  output  16  fetched word (IF/ID register).
- valid  output  1  instruction slot holds a real instruction.
- halted  output  1  FSM is in HALTED.

Behaviour:
- Reset (async, rst=1):
  - fetch_pc=RESET_PC, state=RUN.
  - pc=0, instruction=NOP_WORD, valid=0, halted=0.
  - Memory contents are not reset. imem writes are still accepted while rst=1.
- Memory:
  - Synchronous write, asynchronous read at fetch_pc.
  - A write and a read to the same address in the same cycle returns the old data; the new word is visible next cycle.
- Latency: a word at fetch_pc appears on instruction/pc one clock edge later.
- State RUN, per edge, in priority order:
  1. branch_taken: fetch_pc<=branch_target; instruction<=NOP_WORD; valid<=0 (flush). Overrides stall.
  2. stall: all registers hold, including fetch_pc, pc, instruction and valid.
  3. Otherwise: instruction<=mem[fetch_pc]; pc<=fetch_pc; valid<=1.
     - If the fetched opcode is HALT_OPCODE: fetch_pc holds, state<=HALTED.
     - Else: fetch_pc<=fetch_pc+1, wrapping mod 16 (4'hF -> 4'h0, no flag).
- State HALTED:
  - halted=1.
  - The HALT word stays valid for exactly one un-stalled cycle. Then instruction<=NOP_WORD, valid<=0. If stall is high, the HALT word is held until stall drops.
  - branch_taken: redirect as in RUN, state<=RUN. An older in-flight branch cancels the halt. branch_taken has priority over resume.
  - resume: fetch_pc<=fetch_pc+1, state<=RUN. Takes effect regardless of stall. Fetch resumes on the following edge, subject to stall.
  - resume while in RUN is ignored.
- halted is registered from state (=1 iff state==HALTED).
- Reset asserted mid-operation or mid-halt: all state returns to reset values immediately, without waiting for a clock edge.
- Branch target equal to the current fetch_pc is legal; the same word is refetched.

Decomposition:
- Shared package, also used by the control unit:
  - opcode constants (HALT_OPCODE value), NOP_WORD.
  - fetch state enum {RUN, HALTED}.
  - PC and instruction widths (4, 16).
- One natural sub-module: instr_mem (16x16, sync write, async read), instantiated once inside instruction_fetch.

Test Plan:
- Reset and run:
  - Stimulus: load mem[0..3]=16'h1231,16'h2342,16'h3453,16'h4564; release rst.
  - Required: consecutive edges give pc/instruction = 0/1231, 1/2342, 2/3453, 3/4564, valid=1 from the first edge after reset release.
- Stall:
  - Stimulus: raise stall for 3 cycles while pc=2.
  - Required: pc=2, instruction=3453 and valid=1 held for 3 cycles; pc=3 on the edge after stall drops.
- Branch flush:
  - Stimulus: branch_taken=1, branch_target=4'hA, together with stall=1.
  - Required: next edge valid=0, instruction=0000; following edge pc=A, instruction=mem[A].
- Wrap:
  - Stimulus: branch to 4'hE with no stall.
  - Required: pc sequence E, F, 0, 1, with no gap and no extra flush.
- Halt/resume:
  - Stimulus: mem[5]=16'h000F; run from 4; hold 4 cycles; then pulse resume.
  - Required: pc=5 with instruction 000F valid one cycle; then valid=0, halted=1 for the hold; after resume halted=0 and the next fetch is pc=6.
- Halt vs branch, and async reset:
  - Stimulus: while HALTED assert branch_taken (target 2) and resume together.
  - Required: redirect to pc=2, RUN.
  - Stimulus: assert rst between edges.
  - Required: valid=0, pc=0, halted=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-side constants and types for the 4-bit-PC pipeline.
// Also imported by the control unit for the opcode and NOP encodings.
package instruction_fetch_pkg;

    localparam int PC_W    = 4;
    localparam int INSTR_W = 16;
    localparam int OPC_W   = 4;
    localparam int DEPTH   = 1 << PC_W;

    localparam logic [OPC_W-1:0]   HALT_OPC  = 4'hF;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               valid;
    } if_id_t;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] w);
        return w[OPC_W-1:0];
    endfunction

    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] p);
        logic [PC_W-1:0] one;
        one = '0;
        one[0] = 1'b1;
        return p + one;
    endfunction

endpackage

// File: rtl/instruction_fetch_mem.sv
// 16x16 instruction store: synchronous write, asynchronous read.
// No reset; a same-address write and read in one cycle returns old data.
module instr_mem
    import instruction_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               we_i,
    input  logic [PC_W-1:0]    waddr_i,
    input  logic [INSTR_W-1:0] wdata_i,
    input  logic [PC_W-1:0]    raddr_i,
    output logic [INSTR_W-1:0] rdata_o
);

    logic [INSTR_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: fetch PC, instruction memory and the IF/ID register,
// with stall, branch flush and a HALT opcode that parks fetch.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0]    RESET_PC    = 4'h0,
    parameter logic [OPC_W-1:0]   HALT_OPCODE = HALT_OPC,
    parameter logic [INSTR_W-1:0] NOP_WORD    = NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               resume,
    input  logic               imem_we,
    input  logic [PC_W-1:0]    imem_waddr,
    input  logic [INSTR_W-1:0] imem_wdata,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] instruction,
    output logic               valid,
    output logic               halted
);

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
    if_id_t             ifid_q, ifid_d;
    logic [INSTR_W-1:0] rdata;

    instr_mem u_mem (
        .clk     (clk),
        .we_i    (imem_we),
        .waddr_i (imem_waddr),
        .wdata_i (imem_wdata),
        .raddr_i (fetch_pc_q),
        .rdata_o (rdata)
    );

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        ifid_d     = ifid_q;
        priority case (1'b1)
            branch_taken: begin
                fetch_pc_d   = branch_target;
                ifid_d.instr = NOP_WORD;
                ifid_d.valid = 1'b0;
                state_d      = ST_RUN;
            end
            (state_q == ST_HALTED): begin
                // resume is honoured even under stall; the slot only drains unstalled
                if (resume) begin
                    fetch_pc_d = pc_inc(fetch_pc_q);
                    state_d    = ST_RUN;
                end
                if (!stall) begin
                    ifid_d.instr = NOP_WORD;
                    ifid_d.valid = 1'b0;
                end
            end
            !stall: begin
                ifid_d.pc    = fetch_pc_q;
                ifid_d.instr = rdata;
                ifid_d.valid = 1'b1;
                if (opcode_of(rdata) == HALT_OPCODE) begin
                    state_d = ST_HALTED;
                end else begin
                    fetch_pc_d = pc_inc(fetch_pc_q);
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            fetch_pc_q   <= RESET_PC;
            ifid_q.pc    <= '0;
            ifid_q.instr <= NOP_WORD;
            ifid_q.valid <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            ifid_q     <= ifid_d;
        end
    end

    assign pc          = ifid_q.pc;
    assign instruction = ifid_q.instr;
    assign valid       = ifid_q.valid;
    assign halted      = (state_q == ST_HALTED);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios
// plus randomized traffic against a rule-level reference model.
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [3:0]  branch_target;
    logic        resume;
    logic        imem_we;
    logic [3:0]  imem_waddr;
    logic [15:0] imem_wdata;
    logic [3:0]  pc;
    logic [15:0] instruction;
    logic        valid;
    logic        halted;

    int total;
    int bad;

    logic [15:0] m_mem [16];
    logic [3:0]  m_fpc;
    logic        m_halt;
    logic [3:0]  m_pc;
    logic [15:0] m_ins;
    logic        m_val;

    instruction_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .resume        (resume),
        .imem_we       (imem_we),
        .imem_waddr    (imem_waddr),
        .imem_wdata    (imem_wdata),
        .pc            (pc),
        .instruction   (instruction),
        .valid         (valid),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_fpc  = 4'h0;
        m_halt = 1'b0;
        m_pc   = 4'h0;
        m_ins  = 16'h0000;
        m_val  = 1'b0;
    endtask

    // Applies one clock edge worth of the fetch rules to the model.
    task automatic model_edge();
        logic [15:0] w;
        w = m_mem[m_fpc];
        if (rst) begin
            model_reset();
        end else if (branch_taken) begin
            m_fpc  = branch_target;
            m_ins  = 16'h0000;
            m_val  = 1'b0;
            m_halt = 1'b0;
        end else if (m_halt) begin
            if (resume) begin
                m_fpc  = 4'((int'(m_fpc) + 1) % 16);
                m_halt = 1'b0;
            end
            if (!stall) begin
                m_ins = 16'h0000;
                m_val = 1'b0;
            end
        end else if (!stall) begin
            m_ins = w;
            m_pc  = m_fpc;
            m_val = 1'b1;
            if (w[3:0] == 4'hF) m_halt = 1'b1;
            else m_fpc = 4'((int'(m_fpc) + 1) % 16);
        end
        if (imem_we) m_mem[imem_waddr] = imem_wdata;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 4'h0;
        resume        = 1'b0;
        imem_we       = 1'b0;
        imem_waddr    = 4'h0;
        imem_wdata    = 16'h0000;
    endtask

    task automatic test_reset();
        logic [3:0]  addrs [10];
        logic [15:0] words [10];
        logic [21:0] exp;
        addrs = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
                  4'h5, 4'h6, 4'hA, 4'hE, 4'hF};
        words = '{16'h1231, 16'h2342, 16'h3453, 16'h4564, 16'h4440,
                  16'h000F, 16'h6660, 16'hA5A0, 16'hE0E1, 16'hF0F2};
        rst = 1'b1;
        idle_inputs();
        model_reset();
        #2;
        exp = {4'h0, 16'h0000, 1'b0, 1'b0};
        total++;
        if ({pc, instruction, valid, halted} !== exp) begin
            bad++;
            $display("FAIL reset_state got=%h exp=%h",
                     {pc, instruction, valid, halted}, exp);
        end
        for (int i = 0; i < 10; i++) begin
            imem_we    = 1'b1;
            imem_waddr = addrs[i];
            imem_wdata = words[i];
            step();
        end
        idle_inputs();
        total++;
        if ({pc, instruction, valid, halted} !== exp) begin
            bad++;
            $display("FAIL reset_hold got=%h exp=%h",
                     {pc, instruction, valid, halted}, exp);
        end
        rst = 1'b0;
    endtask

    task automatic test_run();
        logic [21:0] exp [3];
        exp = '{{4'h0, 16'h1231, 1'b1, 1'b0},
                {4'h1, 16'h2342, 1'b1, 1'b0},
                {4'h2, 16'h3453, 1'b1, 1'b0}};
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({pc, instruction, valid, halted} !== exp[i]) begin
                bad++;
                $display("FAIL run_%0d got=%h exp=%h", i,
                         {pc, instruction, valid, halted}, exp[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [21:0] exp;
        exp = {4'h2, 16'h3453, 1'b1, 1'b0};
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({pc, instruction, valid, halted} !== exp) begin
                bad++;
                $display("FAIL stall_%0d got=%h exp=%h", i,
                         {pc, instruction, valid, halted}, exp);
            end
        end
        stall = 1'b0;
        step();
        exp = {4'h3, 16'h4564, 1'b1, 1'b0};
        total++;
        if ({pc, instruction, valid, halted} !== exp) begin
            bad++;
            $display("FAIL stall_release got=%h exp=%h",
                     {pc, instruction, valid, halted}, exp);
        end
    endtask

    task automatic test_branch_flush();
        logic [21:0] exp;
        branch_taken  = 1'b1;
        branch_target = 4'hA;
        stall         = 1'b1;
        step();
        idle_inputs();
        exp = {4'h3, 16'h0000, 1'b0, 1'b0};
        total++;
        if ({pc, instruction, valid, halted} !== exp) begin
            bad++;
            $display("FAIL flush got=%h exp=%h",
                     {pc, instruction, valid, halted}, exp);
        end
        step();
        exp = {4'hA, 16'hA5A0, 1'b1, 1'b0};
        total++;
        if ({pc, instruction, valid, halted} !== exp) begin
            bad++;
            $display("FAIL flush_target got=%h exp=%h",
                     {pc, instruction, valid, halted}, exp);
        end
    endtask

    task automatic test_wrap();
        logic [21:0] exp [4];
        exp = '{{4'hE, 16'hE0E1, 1'b1, 1'b0},
                {4'hF, 16'hF0F2, 1'b1, 1'b0},
                {4'h0, 16'h1231, 1'b1, 1'b0},
                {4'h1, 16'h2342, 1'b1, 1'b0}};
        branch_taken  = 1'b1;
        branch_target = 4'hE;
        step();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if ({pc, instruction, valid, halted} !== exp[i]) begin
                bad++;
                $display("FAIL wrap_%0d got=%h exp=%h", i,
                         {pc, instruction, valid, halted}, exp[i]);
            end
        end
    endtask

    task automatic test_halt_resume();
        logic [21:0] exp;
        branch_taken  = 1'b1;
        branch_target = 4'h4;
        step();
        idle_inputs();
        step();
        step();
        exp = {4'h5, 16'h000F, 1'b1, 1'b1};
        total++;
        if ({pc, instruction, valid, halted} !== exp) begin
            bad++;
            $display("FAIL halt_word got=%h exp=%h",
                     {pc, instruction, valid, halted}, exp);
        end
        stall = 1'b1;
        step();
        stall = 1'b0;
        total++;
        if ({pc, instruction, valid, halted} !== exp) begin
            bad++;
            $display("FAIL halt_stalled got=%h exp=%h",
                     {pc, instruction, valid, halted}, exp);
        end
        exp = {4'h5, 16'h0000, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if ({pc, instruction, valid, halted} !== exp) begin
                bad++;
                $display("FAIL halt_hold_%0d got=%h exp=%h", i,
                         {pc, instruction, valid, halted}, exp);
            end
        end
        resume = 1'b1;
        step();
        resume = 1'b0;
        exp = {4'h5, 16'h0000, 1'b0, 1'b0};
        total++;
        if ({pc, instruction, valid, halted} !== exp) begin
            bad++;
            $display("FAIL resume got=%h exp=%h",
                     {pc, instruction, valid, halted}, exp);
        end
        step();
        exp = {4'h6, 16'h6660, 1'b1, 1'b0};
        total++;
        if ({pc, instruction, valid, halted} !== exp) begin
            bad++;
            $display("FAIL resume_fetch got=%h exp=%h",
                     {pc, instruction, valid, halted}, exp);
        end
    endtask

    task automatic test_halt_branch();
        logic [21:0] exp;
        branch_taken  = 1'b1;
        branch_target = 4'h5;
        step();
        idle_inputs();
        step();
        total++;
        if (halted !== 1'b1) begin
            bad++;
            $display("FAIL halt_again got=%b exp=1", halted);
        end
        branch_taken  = 1'b1;
        branch_target = 4'h2;
        resume        = 1'b1;
        step();
        idle_inputs();
        exp = {4'h5, 16'h0000, 1'b0, 1'b0};
        total++;
        if ({pc, instruction, valid, halted} !== exp) begin
            bad++;
            $display("FAIL halt_branch got=%h exp=%h",
                     {pc, instruction, valid, halted}, exp);
        end
        step();
        exp = {4'h2, 16'h3453, 1'b1, 1'b0};
        total++;
        if ({pc, instruction, valid, halted} !== exp) begin
            bad++;
            $display("FAIL halt_branch_fetch got=%h exp=%h",
                     {pc, instruction, valid, halted}, exp);
        end
    endtask

    task automatic test_async_reset();
        logic [21:0] exp;
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        exp = {4'h0, 16'h0000, 1'b0, 1'b0};
        total++;
        if ({pc, instruction, valid, halted} !== exp) begin
            bad++;
            $display("FAIL async_reset got=%h exp=%h",
                     {pc, instruction, valid, halted}, exp);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] d;
        logic [21:0] exp;
        rst = 1'b1;
        for (int a = 0; a < 16; a++) begin
            d = 16'($urandom);
            if ($urandom_range(5) == 0) d[3:0] = 4'hF;
            else if (d[3:0] == 4'hF) d[3:0] = 4'h1;
            imem_we    = 1'b1;
            imem_waddr = 4'(a);
            imem_wdata = d;
            step();
        end
        idle_inputs();
        rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            d = 16'($urandom);
            if ($urandom_range(5) == 0) d[3:0] = 4'hF;
            else if (d[3:0] == 4'hF) d[3:0] = 4'h2;
            stall         = ($urandom_range(3) == 0);
            branch_taken  = ($urandom_range(9) == 0);
            branch_target = 4'($urandom);
            resume        = ($urandom_range(5) == 0);
            imem_we       = ($urandom_range(2) == 0);
            imem_waddr    = 4'($urandom);
            imem_wdata    = d;
            step();
            exp = {m_pc, m_ins, m_val, m_halt};
            total++;
            if ({pc, instruction, valid, halted} !== exp) begin
                bad++;
                $display("FAIL random_%0d got=%h exp=%h", i,
                         {pc, instruction, valid, halted}, exp);
            end
        end
        idle_inputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_run();
        test_stall();
        test_branch_flush();
        test_wrap();
        test_halt_resume();
        test_halt_branch();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
